// File: rtl/pad_pkg.sv
// Shared constants and judge encoding for the drum-pad hit judge.
package pad_pkg;

    localparam int NUM_PADS_DEFAULT        = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    // Short debounce window so benches finish quickly.
    localparam int SIM_DEBOUNCE            = 4;

    typedef enum logic [1:0] {
        JUDGE_NONE = 2'd0,
        JUDGE_HIT  = 2'd1,
        JUDGE_MISS = 2'd2
    } judge_e;

endpackage

// File: rtl/pad_debouncer.sv
// Single-pad two-flop synchroniser followed by a stable-count debouncer.
module pad_debouncer
    import pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any return to the stable level restarts the count from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q    <= '0;
            stable_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/pad_hit_judge.sv
// Debounces the drum pads, detects presses and judges them against the lit-pad mask.
module pad_hit_judge
    import pad_pkg::*;
#(
    parameter int NUM_PADS        = NUM_PADS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 19
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         sensor_input,
    input  logic [31:0]         target,
    input  logic                game_enable,
    input  logic                score_clear,
    input  logic                mistake_clear,
    output logic [NUM_PADS-1:0] pad_state,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic [31:0]         score_out,
    output logic [31:0]         mistake
);

    logic [NUM_PADS-1:0] prev_q;
    logic [NUM_PADS-1:0] press;
    logic [NUM_PADS-1:0] tgt;
    judge_e              judge;
    logic                hit_ev;
    logic                miss_ev;
    logic                hit_q;
    logic                miss_q;
    logic [31:0]         score_q;
    logic [31:0]         score_d;
    logic                mistake_q;
    logic                mistake_d;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        pad_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debouncer (
            .clock (clock),
            .reset (reset),
            .raw   (sensor_input[i]),
            .stable(pad_state[i])
        );
    end

    if (NUM_PADS < 32) begin : g_unused
        logic unused_upper;
        assign unused_upper = ^{sensor_input[31:NUM_PADS], target[31:NUM_PADS]};
    end

    assign tgt   = target[NUM_PADS-1:0];
    assign press = pad_state & ~prev_q;

    // Any pressed pad outside the lit mask makes the whole event a miss.
    always_comb begin
        judge = JUDGE_NONE;
        if (press != '0) begin
            if ((press & ~tgt) != '0) begin
                judge = JUDGE_MISS;
            end else begin
                judge = JUDGE_HIT;
            end
        end
    end

    assign hit_ev  = game_enable && (judge == JUDGE_HIT);
    assign miss_ev = game_enable && (judge == JUDGE_MISS);

    always_comb begin
        score_d = score_q;
        if (score_clear) begin
            score_d = '0;
        end else if (hit_ev && (score_q != 32'hFFFF_FFFF)) begin
            score_d = score_q + 32'd1;
        end
    end

    // A mistake arriving with a clear still wins.
    assign mistake_d = miss_ev | (mistake_q & ~mistake_clear);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            score_q   <= '0;
            mistake_q <= 1'b0;
        end else begin
            prev_q    <= pad_state;
            hit_q     <= hit_ev;
            miss_q    <= miss_ev;
            score_q   <= score_d;
            mistake_q <= mistake_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score_out  = score_q;
    assign mistake    = {31'd0, mistake_q};

endmodule

// File: tb/tb_pad_hit_judge.sv
// Directed bench for pad_hit_judge with a shortened debounce window.
module tb_pad_hit_judge;
    import pad_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] sensor_input;
    logic [31:0] target;
    logic        game_enable;
    logic        score_clear;
    logic        mistake_clear;
    logic [2:0]  pad_state;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [31:0] score_out;
    logic [31:0] mistake;

    int n_checks = 0;
    int n_fail   = 0;
    int hits;
    int misses;
    logic        hit_now;
    logic        miss_now;
    logic [31:0] score_now;
    logic [31:0] mistake_now;

    pad_hit_judge #(
        .NUM_PADS       (3),
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE),
        .CNT_W          (19)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sensor_input (sensor_input),
        .target       (target),
        .game_enable  (game_enable),
        .score_clear  (score_clear),
        .mistake_clear(mistake_clear),
        .pad_state    (pad_state),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .score_out    (score_out),
        .mistake      (mistake)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance n clocks, sampling on the falling edge and tallying pulses.
    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clock);
            if (hit_pulse === 1'b1) hits++;
            if (miss_pulse === 1'b1) misses++;
        end
    endtask

    // Press mask, apply the given clears exactly in the judge cycle, then release.
    task automatic press_pulse(input logic [31:0] mask, input logic sc, input logic mc);
        hits   = 0;
        misses = 0;
        sensor_input = mask;
        hold(6);
        score_clear   = sc;
        mistake_clear = mc;
        hold(1);
        hit_now     = hit_pulse;
        miss_now    = miss_pulse;
        score_now   = score_out;
        mistake_now = mistake;
        score_clear   = 1'b0;
        mistake_clear = 1'b0;
        hold(2);
        sensor_input = 32'd0;
        hold(8);
    endtask

    initial begin
        reset         = 1'b1;
        sensor_input  = 32'd0;
        target        = 32'd0;
        game_enable   = 1'b0;
        score_clear   = 1'b0;
        mistake_clear = 1'b0;
        hits          = 0;
        misses        = 0;

        // 1. Reset state and latency
        repeat (2) @(negedge clock);
        check_eq("rst_pad", 32'(pad_state), 32'd0);
        check_eq("rst_hit", 32'(hit_pulse), 32'd0);
        check_eq("rst_miss", 32'(miss_pulse), 32'd0);
        check_eq("rst_score", score_out, 32'd0);
        check_eq("rst_mistake", mistake, 32'd0);
        reset       = 1'b0;
        target      = 32'h1;
        game_enable = 1'b1;
        hold(1);
        sensor_input = 32'h1;
        hold(5);
        check_eq("lat_pad_early", 32'(pad_state), 32'd0);
        hold(1);
        check_eq("lat_pad", 32'(pad_state), 32'h1);
        check_eq("lat_hit_early", 32'(hit_pulse), 32'd0);
        hold(1);
        check_eq("lat_hit", 32'(hit_pulse), 32'd1);
        check_eq("lat_score", score_out, 32'd1);
        sensor_input = 32'd0;
        hold(8);
        check_eq("rel_pad", 32'(pad_state), 32'd0);
        check_eq("rel_hits", 32'(hits), 32'd1);
        check_eq("rel_misses", 32'(misses), 32'd0);

        // 2. Glitch rejection
        hits = 0; misses = 0;
        sensor_input = 32'h2;
        hold(3);
        sensor_input = 32'd0;
        hold(10);
        check_eq("glitch_pad", 32'(pad_state), 32'd0);
        check_eq("glitch_pulses", 32'(hits + misses), 32'd0);
        check_eq("glitch_score", score_out, 32'd1);

        // 3. Wrong pad
        target = 32'h4;
        press_pulse(32'h1, 1'b0, 1'b0);
        check_eq("wrong_miss", 32'(miss_now), 32'd1);
        check_eq("wrong_misses", 32'(misses), 32'd1);
        check_eq("wrong_hits", 32'(hits), 32'd0);
        check_eq("wrong_mistake", mistake, 32'h1);
        check_eq("wrong_score", score_out, 32'd1);
        mistake_clear = 1'b1;
        hold(1);
        mistake_clear = 1'b0;
        check_eq("mclear", mistake, 32'h0);

        // 4. Simultaneous presses
        target = 32'h3;
        press_pulse(32'h3, 1'b0, 1'b0);
        check_eq("dual_hit_now", 32'(hit_now), 32'd1);
        check_eq("dual_hits", 32'(hits), 32'd1);
        check_eq("dual_misses", 32'(misses), 32'd0);
        check_eq("dual_score", score_out, 32'd2);
        target = 32'h1;
        press_pulse(32'h5, 1'b0, 1'b0);
        check_eq("mixed_miss_now", 32'(miss_now), 32'd1);
        check_eq("mixed_hit_now", 32'(hit_now), 32'd0);
        check_eq("mixed_hits", 32'(hits), 32'd0);
        check_eq("mixed_score", score_out, 32'd2);
        check_eq("mixed_mistake", mistake, 32'h1);
        mistake_clear = 1'b1;
        hold(1);
        mistake_clear = 1'b0;

        // 5. Priority
        target = 32'h4;
        press_pulse(32'h1, 1'b0, 1'b1);
        check_eq("prio_mistake", mistake_now, 32'h1);
        check_eq("prio_mistake_hold", mistake, 32'h1);
        mistake_clear = 1'b1;
        hold(1);
        mistake_clear = 1'b0;
        target = 32'h1;
        press_pulse(32'h1, 1'b1, 1'b0);
        check_eq("prio_hit_now", 32'(hit_now), 32'd1);
        check_eq("prio_score", score_now, 32'd0);
        game_enable = 1'b0;
        press_pulse(32'h1, 1'b0, 1'b0);
        check_eq("dis_pulses", 32'(hits + misses), 32'd0);
        check_eq("dis_score", score_out, 32'd0);
        check_eq("dis_mistake", mistake, 32'd0);
        game_enable = 1'b1;

        // 6. Saturation
        force dut.score_q = 32'hFFFF_FFFF;
        hold(1);
        release dut.score_q;
        hold(1);
        check_eq("sat_preload", score_out, 32'hFFFF_FFFF);
        press_pulse(32'h1, 1'b0, 1'b0);
        check_eq("sat_hit", 32'(hit_now), 32'd1);
        check_eq("sat_score", score_out, 32'hFFFF_FFFF);

        // Asynchronous reset mid-debounce
        sensor_input = 32'h1;
        hold(4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_pad", 32'(pad_state), 32'd0);
        check_eq("arst_score", score_out, 32'd0);
        check_eq("arst_mistake", mistake, 32'd0);
        check_eq("arst_pulses", 32'(hit_pulse | miss_pulse), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        hold(5);
        check_eq("arst_pad_early", 32'(pad_state), 32'd0);
        hold(1);
        check_eq("arst_pad_late", 32'(pad_state), 32'h1);
        sensor_input = 32'd0;
        hold(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pad_hit_judge.md
Name: pad_hit_judge

Overview:
- Upstream stage between the raw drum-pad sensors (`sensor_input`) and the processor / vga_controller.
- Synchronises and debounces each pad and detects press edges.
- Judges each press against the currently lit pad mask (`sensor_output`, low bits).
- Produces the 32-bit `score_out` and `mistake` words, which the processor reads at addresses 4 and 5 and which also feed the VGA controller.

Parameters:
- NUM_PADS, 3, number of pads; uses `sensor_input[NUM_PADS-1:0]` and `target[NUM_PADS-1:0]`.
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before accepting a change (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock, input, 1, system clock (CLOCK_50 domain).
- reset, input, 1, asynchronous active-high reset.
- sensor_input, input, 32, raw pad levels; 1 = pad pressed; bits above NUM_PADS-1 are ignored.
- target, input, 32, lit-pad mask driven to sensor_output; only [NUM_PADS-1:0] are used.
- game_enable, input, 1, judging enabled (dummy/game screen active).
- score_clear, input, 1, synchronous score clear.
- mistake_clear, input, 1, synchronous mistake clear.
- pad_state, output, NUM_PADS, debounced pad levels.
- hit_pulse, output, 1, one-cycle pulse on a correct press.
- miss_pulse, output, 1, one-cycle pulse on a wrong press.
- score_out, output, 32, count of correct presses.
- mistake, output, 32, bit 0 is the sticky mistake flag; [31:1] are always 0.

Behaviour:
- Reset (async, active-high): all of the following clear to 0 immediately:
  - sync flops, debounce counters, pad_state, previous-state register
  - hit_pulse, miss_pulse, score_out, mistake
- Reset asserted mid-debounce discards the pending change.
- Synchroniser: two flops per pad; the debouncer sees sync2.
- Debounce, per pad i:
  - If sync2[i] == pad_state[i], counter ← 0.
  - Otherwise the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync2[i] still differs, pad_state[i] ← sync2[i] and counter ← 0.
  - Any glitch back to the stable value before the threshold restarts the count.
- Latency from a raw edge held steady to the pad_state change: 2 + DEBOUNCE_CYCLES clocks.
- Press detect: press[i] = pad_state[i] & ~prev_state[i], where prev_state is pad_state registered one cycle.
  - Releases generate nothing.
- Judge, registered; outputs appear 1 cycle after press. Let P = press vector, T = target[NUM_PADS-1:0].
  - game_enable == 0: no pulses, score and mistake hold; debouncing continues.
  - P == 0: no event.
  - (P & ~T) != 0: miss_pulse = 1, no score change. This includes T == 0 and a mixed correct+wrong simultaneous press.
  - Otherwise (P != 0 and P ⊆ T): hit_pulse = 1 and score_out += 1. At most one increment per cycle regardless of popcount(P).
  - hit_pulse and miss_pulse are never high in the same cycle.
- Score:
  - Saturates at 0xFFFF_FFFF.
  - score_clear has priority over a same-cycle hit (score_out = 0 next cycle; hit_pulse still fires).
- Mistake:
  - mistake[0] is set by miss_pulse's source event and cleared by mistake_clear.
  - A same-cycle set and clear results in set (a mistake is never lost).
- target is sampled combinationally at judge time; it is not synchronised (same clock domain as the processor).

Decomposition:
- Package pad_pkg holds:
  - NUM_PADS_DEFAULT and DEBOUNCE_CYCLES_DEFAULT
  - the SIM_DEBOUNCE = 4 constant for benches
  - the judge result encoding (JUDGE_NONE, JUDGE_HIT, JUDGE_MISS).
- One natural sub-module: pad_debouncer (single-bit 2-flop sync + counter + stable output), instantiated NUM_PADS times via generate.
- Edge detect, judge and counters stay in pad_hit_judge.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_PADS = 3):
1. Reset/latency:
   - Assert reset → all outputs are 0.
   - Release reset, raise sensor_input = 0x1 and hold → pad_state = 3'b001 exactly 6 clocks later.
   - hit_pulse one clock after that with target = 0x1 and game_enable = 1; score_out = 1.
2. Glitch rejection: sensor_input bit 1 high for 3 clocks then low → pad_state stays 0, no pulses, score_out unchanged.
3. Wrong pad: target = 0x4, press pad 0 → miss_pulse one cycle, mistake = 0x1, score_out unchanged. mistake_clear → mistake = 0x0.
4. Simultaneous press:
   - target = 0x3, pads 0 and 1 pressed in the same cycle → one hit_pulse, score_out += 1.
   - target = 0x1, pads 0 and 2 pressed → miss_pulse only, no score change.
5. Priority:
   - mistake_clear in the same cycle as a miss → mistake = 0x1.
   - score_clear in the same cycle as a hit → score_out = 0.
   - game_enable = 0 with a press → no pulses.
6. Saturation and mid-operation reset:
   - Force score_out to 0xFFFF_FFFF, then hit → score_out stays 0xFFFF_FFFF.
   - Assert reset asynchronously mid-debounce → outputs 0 immediately; the pad must then be re-held 6 clocks to register.
